// File: rtl/time_syn_rx.sv
// Receive-side parser for fixed-length time-sync frames: classifies the beat-0 preamble, captures
// the beat-1 timestamp plus local arrival time, and reports one pulse per frame.
module time_syn_rx #(
  parameter int unsigned P_FRAME_LEN   = 8,
  parameter logic [63:0] P_TS_PRE      = 64'h66,
  parameter logic [63:0] P_STD_PRE     = 64'h88,
  parameter logic [63:0] P_RETURN_PRE  = 64'h55,
  parameter bit          P_CHECK_TLAST = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_local_time,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic        o_rx_axis_tready,
  output logic        o_recv_ts_valid,
  output logic        o_recv_std_valid,
  output logic        o_recv_return_valid,
  output logic [63:0] o_recv_time,
  output logic [63:0] o_arrive_time,
  output logic        o_frame_err
);

  localparam int unsigned   CntW    = (P_FRAME_LEN > 1) ? $clog2(P_FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(P_FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StTs, StDrain, StDrop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bad_q, bad_d;
  logic [2:0]      type_q, type_d;  // {return, std, ts}
  logic [63:0]     arr_shadow_q, arr_shadow_d;
  logic [63:0]     time_shadow_q, time_shadow_d;
  logic            tready_q;
  logic            ts_valid_q, ts_valid_d;
  logic            std_valid_q, std_valid_d;
  logic            ret_valid_q, ret_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [63:0]     recv_time_q, recv_time_d;
  logic [63:0]     arrive_time_q, arrive_time_d;

  logic       acc, is_last, early_end, frame_end, beat_bad, frame_bad, frame_good;
  logic [2:0] hit;

  always_comb begin
    acc       = i_rx_axis_tvalid & tready_q;
    is_last   = (cnt_q == LastCnt);
    early_end = P_CHECK_TLAST && i_rx_axis_tlast && !is_last;
    frame_end = acc && (is_last || early_end);
    beat_bad  = i_rx_axis_tuser || (i_rx_axis_tkeep != 8'hFF) || early_end;
    // Only a frame that reached the drain state has both a valid preamble and a timestamp.
    frame_bad = bad_q || beat_bad || (P_CHECK_TLAST && is_last && !i_rx_axis_tlast) ||
                (state_q != StDrain);
    frame_good = frame_end && !frame_bad;
    hit = {i_rx_axis_tdata == P_RETURN_PRE,
           i_rx_axis_tdata == P_STD_PRE,
           i_rx_axis_tdata == P_TS_PRE};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bad_d         = bad_q;
    type_d        = type_q;
    arr_shadow_d  = arr_shadow_q;
    time_shadow_d = time_shadow_q;
    if (acc) begin
      if (frame_end) begin
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        bad_d = bad_q || beat_bad;
        unique case (state_q)
          StIdle:  state_d = (hit != 3'b000) ? StTs : StDrop;
          StTs:    state_d = StDrain;
          StDrain: state_d = StDrain;
          StDrop:  state_d = StDrop;
          default: state_d = StDrop;
        endcase
      end
      if (state_q == StIdle) begin
        // Priority pick so type stays one-hot even if preambles were configured equal.
        type_d       = hit[0] ? 3'b001 : (hit[1] ? 3'b010 : (hit[2] ? 3'b100 : 3'b000));
        arr_shadow_d = i_local_time;
      end
      if (state_q == StTs) begin
        time_shadow_d = i_rx_axis_tdata;
      end
    end
  end

  always_comb begin
    ts_valid_d    = frame_good && type_q[0];
    std_valid_d   = frame_good && type_q[1];
    ret_valid_d   = frame_good && type_q[2];
    frame_err_d   = frame_end && frame_bad;
    recv_time_d   = frame_good ? time_shadow_q : recv_time_q;
    arrive_time_d = frame_good ? arr_shadow_q : arrive_time_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bad_q         <= 1'b0;
      type_q        <= 3'b000;
      arr_shadow_q  <= '0;
      time_shadow_q <= '0;
      tready_q      <= 1'b0;
      ts_valid_q    <= 1'b0;
      std_valid_q   <= 1'b0;
      ret_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      recv_time_q   <= '0;
      arrive_time_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bad_q         <= bad_d;
      type_q        <= type_d;
      arr_shadow_q  <= arr_shadow_d;
      time_shadow_q <= time_shadow_d;
      tready_q      <= 1'b1;
      ts_valid_q    <= ts_valid_d;
      std_valid_q   <= std_valid_d;
      ret_valid_q   <= ret_valid_d;
      frame_err_q   <= frame_err_d;
      recv_time_q   <= recv_time_d;
      arrive_time_q <= arrive_time_d;
    end
  end

  assign o_rx_axis_tready    = tready_q;
  assign o_recv_ts_valid     = ts_valid_q;
  assign o_recv_std_valid    = std_valid_q;
  assign o_recv_return_valid = ret_valid_q;
  assign o_frame_err         = frame_err_q;
  assign o_recv_time         = recv_time_q;
  assign o_arrive_time       = arrive_time_q;

endmodule

// File: tb/tb_time_syn_rx.sv
// Bench for time_syn_rx: one instance per tlast mode, both fed the same stream and compared each
// cycle against a frame-buffer model, plus literal spot checks on the directed frames.
module tb_time_syn_rx;

  localparam int Len = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] lt = 64'd0;
  logic [63:0] tdata = 64'd0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [7:0]  tkeep = 8'hFF;

  logic        rdy[2], tsv[2], stdv[2], retv[2], ferr[2];
  logic [63:0] rtime[2], atime[2];

  time_syn_rx #(.P_CHECK_TLAST(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_local_time(lt),
    .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
    .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser), .o_rx_axis_tready(rdy[0]),
    .o_recv_ts_valid(tsv[0]), .o_recv_std_valid(stdv[0]), .o_recv_return_valid(retv[0]),
    .o_recv_time(rtime[0]), .o_arrive_time(atime[0]), .o_frame_err(ferr[0])
  );

  time_syn_rx #(.P_CHECK_TLAST(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_local_time(lt),
    .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
    .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser), .o_rx_axis_tready(rdy[1]),
    .o_recv_ts_valid(tsv[1]), .o_recv_std_valid(stdv[1]), .o_recv_return_valid(retv[1]),
    .o_recv_time(rtime[1]), .o_arrive_time(atime[1]), .o_frame_err(ferr[1])
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
  endtask

  // Model: buffer accepted beats per instance, judge the whole frame when it ends.
  typedef struct packed {
    logic [63:0] data;
    logic [63:0] tm;
    logic [7:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  beat_t       fb[2][Len];
  int          fn[2];
  logic        e_rdy[2], e_ts[2], e_std[2], e_ret[2], e_err[2];
  logic [63:0] e_rt[2], e_at[2];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          fn[k] = 0; e_rdy[k] = 0; e_ts[k] = 0; e_std[k] = 0; e_ret[k] = 0; e_err[k] = 0;
          e_rt[k] = 0; e_at[k] = 0;
        end else begin
          bit ck;
          bit bad;
          bit early;
          ck = (k == 1);
          e_ts[k] = 0; e_std[k] = 0; e_ret[k] = 0; e_err[k] = 0;
          if (tvalid && e_rdy[k]) begin
            fb[k][fn[k]].data = tdata;
            fb[k][fn[k]].tm   = lt;
            fb[k][fn[k]].keep = tkeep;
            fb[k][fn[k]].user = tuser;
            fb[k][fn[k]].last = tlast;
            fn[k]++;
            early = ck && tlast && (fn[k] != Len);
            if (early || fn[k] == Len) begin
              bad = 0;
              for (int i = 0; i < fn[k]; i++) begin
                if (fb[k][i].user || fb[k][i].keep != 8'hFF) bad = 1;
                if (ck && fb[k][i].last && i != Len - 1) bad = 1;
              end
              if (ck && fn[k] == Len && !fb[k][Len-1].last) bad = 1;
              if (!(fb[k][0].data == 64'h66 || fb[k][0].data == 64'h88 ||
                    fb[k][0].data == 64'h55)) bad = 1;
              if (bad) e_err[k] = 1;
              else begin
                e_ts[k]  = (fb[k][0].data == 64'h66);
                e_std[k] = (fb[k][0].data == 64'h88);
                e_ret[k] = (fb[k][0].data == 64'h55);
                e_rt[k]  = fb[k][1].data;
                e_at[k]  = fb[k][0].tm;
              end
              fn[k] = 0;
            end
          end
          e_rdy[k] = 1;
        end
      end
    end
  end

  // Per-cycle compare, on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        string s;
        s = $sformatf("dut%0d_", k);
        chk({s, "tready"},     64'(rdy[k]),  rst_n ? 64'(e_rdy[k]) : 64'd0);
        chk({s, "ts_valid"},   64'(tsv[k]),  rst_n ? 64'(e_ts[k])  : 64'd0);
        chk({s, "std_valid"},  64'(stdv[k]), rst_n ? 64'(e_std[k]) : 64'd0);
        chk({s, "ret_valid"},  64'(retv[k]), rst_n ? 64'(e_ret[k]) : 64'd0);
        chk({s, "frame_err"},  64'(ferr[k]), rst_n ? 64'(e_err[k]) : 64'd0);
        chk({s, "recv_time"},  rtime[k],     rst_n ? e_rt[k] : 64'd0);
        chk({s, "arrive_time"}, atime[k],    rst_n ? e_at[k] : 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lt = lt + 64'd1;
  endtask

  task automatic beat(input logic [63:0] d, input bit last, input logic [7:0] keep,
                      input bit user, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int i = 0; i < g; i++) begin
      tvalid = 0; tdata = {$urandom, $urandom}; tlast = $urandom_range(1, 0);
      tuser = $urandom_range(1, 0); tkeep = 8'($urandom);
      tick();
    end
    tvalid = 1; tdata = d; tlast = last; tkeep = keep; tuser = user;
    tick();
    tvalid = 0; tlast = 0; tuser = 0; tkeep = 8'hFF;
  endtask

  // err_kind: 0 none, 1 tuser on err_beat, 2 tkeep=0F on err_beat
  task automatic frame(input logic [63:0] pre, input logic [63:0] ts, input int err_beat,
                       input int err_kind, input int gap);
    for (int b = 0; b < Len; b++) begin
      logic [63:0] d;
      d = (b == 0) ? pre : ((b == 1) ? ts : {$urandom, $urandom});
      beat(d, b == Len - 1, (b == err_beat && err_kind == 2) ? 8'h0F : 8'hFF,
           b == err_beat && err_kind == 1, gap);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_tready0", 64'(rdy[0]), 64'd0);
    chk("reset_recv_time", rtime[1], 64'd0);
    rst_n = 1;
    tick();
    chk("tready_after_release", 64'(rdy[0] & rdy[1]), 64'd1);

    // Single timestamp frame with known arrival time
    lt = 64'd100;
    frame(64'h66, 64'h1234, -1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("t1_ts_valid", 64'(tsv[k]), 64'd1);
      chk("t1_recv_time", rtime[k], 64'h1234);
      chk("t1_arrive_time", atime[k], 64'd100);
      chk("t1_frame_err", 64'(ferr[k]), 64'd0);
    end

    // Back-to-back std, return, ts
    frame(64'h88, 64'hAAAA, -1, 0, 0);
    chk("b2b_std", 64'(stdv[0]), 64'd1);
    chk("b2b_std_time", rtime[0], 64'hAAAA);
    frame(64'h55, 64'hBBBB, -1, 0, 0);
    chk("b2b_ret", 64'(retv[1]), 64'd1);
    chk("b2b_ret_time", rtime[1], 64'hBBBB);
    frame(64'h66, 64'hCCCC, -1, 0, 0);
    chk("b2b_ts", 64'(tsv[0]), 64'd1);
    chk("b2b_ts_time", rtime[0], 64'hCCCC);

    // Unknown preamble, then a good frame
    frame(64'h77, 64'hDDDD, -1, 0, 0);
    chk("bad_pre_err", 64'(ferr[0]), 64'd1);
    chk("bad_pre_no_valid", 64'(tsv[0] | stdv[0] | retv[0]), 64'd0);
    chk("bad_pre_hold", rtime[0], 64'hCCCC);
    frame(64'h66, 64'hEEEE, -1, 0, 0);
    chk("after_bad_ts", 64'(tsv[1]), 64'd1);

    // tuser and tkeep errors
    frame(64'h55, 64'h1111, 4, 1, 0);
    chk("tuser_err", 64'(ferr[0]), 64'd1);
    chk("tuser_no_ret", 64'(retv[0]), 64'd0);
    frame(64'h55, 64'h2222, 1, 2, 0);
    chk("tkeep_err", 64'(ferr[1]), 64'd1);
    chk("tkeep_hold", rtime[1], 64'hEEEE);

    // Random frames with gaps and occasional corruption
    for (int f = 0; f < 40; f++) begin
      logic [63:0] pre;
      int sel;
      sel = $urandom_range(3, 0);
      pre = (sel == 0) ? 64'h66 : (sel == 1) ? 64'h88 : (sel == 2) ? 64'h55 : {$urandom, $urandom};
      frame(pre, {$urandom, $urandom}, $urandom_range(Len - 1, 0),
            ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0, 2);
    end

    // Early tlast on beat 3: only the tlast-checking instance ends the frame there
    for (int b = 0; b < 4; b++) beat((b == 0) ? 64'h88 : 64'h9, b == 3, 8'hFF, 0, 0);
    chk("early_tlast_err", 64'(ferr[1]), 64'd1);
    frame(64'h88, 64'h3333, -1, 0, 0);
    chk("after_early_std", 64'(stdv[1]), 64'd1);
    chk("after_early_time", rtime[1], 64'h3333);

    // Reset in the middle of a frame
    for (int b = 0; b < 4; b++) beat((b == 0) ? 64'h66 : 64'h4444, 0, 8'hFF, 0, 0);
    rst_n = 0;
    tick();
    chk("midrst_tready", 64'(rdy[1]), 64'd0);
    chk("midrst_err", 64'(ferr[1]), 64'd0);
    tick();
    rst_n = 1;
    tick();
    frame(64'h66, 64'h5555, -1, 0, 1);
    chk("post_rst_ts", 64'(tsv[1]), 64'd1);
    chk("post_rst_time", rtime[1], 64'h5555);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/time_syn_rx.md
Name: time_syn_rx

Overview:
- Receive-side parser for the time-synchronisation link. Sits directly downstream of the link's AXI-Stream RX path and consumes the fixed 8-beat frames produced by the peer's time-sync transmitter.
- Identifies the frame type from the beat-0 preamble and captures the beat-1 timestamp. Stamps the arrival with local time.
- Issues one valid pulse per good frame to the time-sync control logic: timestamp request, standard time, or return timestamp.

Parameters:
- P_FRAME_LEN, 8, beats per frame (≥3).
- P_TS_PRE, 64'h66, preamble of a timestamp (local time) frame.
- P_STD_PRE, 64'h88, preamble of a standard-time frame.
- P_RETURN_PRE, 64'h55, preamble of a return-timestamp frame.
- P_CHECK_TLAST, 0, 1 = require tlast on beat P_FRAME_LEN-1 and on no other beat; 0 = framing by beat counter only, tlast ignored.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, asynchronous, active-low reset.
- i_local_time, input, 64, free-running local time counter.
- i_rx_axis_tvalid, input, 1, stream valid.
- i_rx_axis_tdata, input, 64, stream data.
- i_rx_axis_tlast, input, 1, stream last.
- i_rx_axis_tkeep, input, 8, byte enables.
- i_rx_axis_tuser, input, 1, 1 = beat corrupted (MAC error).
- o_rx_axis_tready, output, 1, stream ready.
- o_recv_ts_valid, output, 1, 1-cycle pulse: good 0x66 frame received.
- o_recv_std_valid, output, 1, 1-cycle pulse: good 0x88 frame received.
- o_recv_return_valid, output, 1, 1-cycle pulse: good 0x55 frame received.
- o_recv_time, output, 64, beat-1 timestamp of the last good frame.
- o_arrive_time, output, 64, i_local_time sampled at the beat-0 handshake of the last good frame.
- o_frame_err, output, 1, 1-cycle pulse: frame discarded.

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs 0, FSM to S_IDLE, beat counter 0. o_rx_axis_tready goes to 1 on the first clock edge after release and stays 1. The block never back-pressures.
- Handshake: a beat is accepted only when i_rx_axis_tvalid & o_rx_axis_tready. Stalls (tvalid=0) hold all state.
- Beat counter: 0..P_FRAME_LEN-1. Increments per accepted beat and wraps to 0 after the beat at P_FRAME_LEN-1.
- Beat 0 (counter 0, S_IDLE):
  - Full 64-bit tdata is compared to the three preambles.
  - Match: latch type and i_local_time into a shadow arrival register, go to S_TS.
  - No match: go to S_DROP.
- Beat 1 (S_TS): latch tdata into the shadow time register, go to S_DRAIN.
- Beats 2..P_FRAME_LEN-1 (S_DRAIN/S_DROP): payload ignored.
- Sticky bad flag, set on any accepted beat with:
  - tuser=1, or
  - tkeep≠8'hFF, or
  - (P_CHECK_TLAST=1 and tlast on a beat other than P_FRAME_LEN-1).
- Frame end:
  - Normal end is the accepted beat at counter P_FRAME_LEN-1.
  - With P_CHECK_TLAST=1, a tlast=1 beat before that ends the frame early: counter to 0, FSM to S_IDLE, frame treated as bad.
  - With P_CHECK_TLAST=1, tlast=0 on beat P_FRAME_LEN-1 also marks the frame bad.
- Reporting (registered), on the cycle after frame end:
  - Good frame: exactly one of o_recv_ts_valid / o_recv_std_valid / o_recv_return_valid pulses. o_recv_time and o_arrive_time update from the shadows in the same cycle and hold until the next good frame.
  - Bad or dropped frame: o_frame_err pulses, no valid pulse, o_recv_time/o_arrive_time unchanged.
- Back-to-back frames: a beat 0 accepted the cycle after frame end is parsed normally, and the pulse for the previous frame is still issued. Maximum rate is one report per P_FRAME_LEN cycles.
- Reset mid-frame: partial frame discarded silently (no o_frame_err). Parsing restarts at beat 0.
- Timestamp arithmetic: none. Values are passed through unmodified; delay compensation belongs to the control logic.

Test Plan:
- Reset then one 8-beat frame, beat0=64'h66, beat1=64'h0000_0000_0000_1234, i_local_time=100 at beat0 -> o_recv_ts_valid high for one cycle, 1 clk after beat 7; o_recv_time=0x1234; o_arrive_time=100; o_frame_err=0.
- Three back-to-back frames with preambles 0x88, 0x55, 0x66, no idle cycles -> three pulses, 8 clk apart, in order std, return, ts; each o_recv_time matches its beat 1.
- Frame with beat0=64'h77 -> o_frame_err pulse after beat 7; no valid pulse; o_recv_time keeps its previous value. Next 0x66 frame is reported correctly.
- 0x55 frame with tuser=1 on beat 4 -> o_frame_err, no o_recv_return_valid. Repeat with tkeep=8'h0F on beat 1 -> same result.
- P_CHECK_TLAST=1: tlast on beat 3 -> o_frame_err after beat 3; the following beat is treated as beat 0. A correct 0x88 frame with tlast on beat 7 -> o_recv_std_valid.
- i_rst low at beat 4 of a 0x66 frame, then released -> no pulses, tready=0 during reset; a fresh frame after release is reported normally. Random tvalid gaps inside a frame -> identical results to the gap-free case.
